// File: rtl/rsc2_cstate_acc.sv
// rsc2_cstate_acc
//   Pre-encoding state accumulator for the rsc2 circular (tail-biting)
//   duo-binary encoder. During the first encoding pass it runs the 16-state
//   recursive trellis from the all-zero state. It also tracks the packet
//   length modulo 15 and the raw symbol count. At end of packet it registers
//   the final state S0N and N mod 15. These values address the
//   circulation-state table.
//
// Parameters
//   pNUM_W   width of the symbol counter (max N = 2^pNUM_W - 1)
//
// Ports
//   iclk      clock
//   ireset    asynchronous active-low reset
//   iclkena   clock enable, freezes all state when low
//   ival      symbol valid
//   isop      first symbol of packet (qualified by ival)
//   ieop      last symbol of packet (qualified by ival)
//   idat      duo-binary symbol, idat[1] = A, idat[0] = B
//   obusy     packet in progress
//   oval      result valid, one enabled-cycle pulse
//   ostate    final trellis state S0N
//   oNmod15   N mod 15 (0..14)
//   onum      symbol count N (saturating)
//   oerr      result unusable: N mod 15 == 0 or length overflow
module rsc2_cstate_acc #(
  parameter int pNUM_W = 13
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ival,
  input  logic              isop,
  input  logic              ieop,
  input  logic [1:0]        idat,
  output logic              obusy,
  output logic              oval,
  output logic [3:0]        ostate,
  output logic [3:0]        oNmod15,
  output logic [pNUM_W-1:0] onum,
  output logic              oerr
);

  localparam logic [pNUM_W-1:0] CNT_MAX = {pNUM_W{1'b1}};

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t              fsm_reg, fsm_next;
  logic [3:0]        s_reg, s_next;
  logic [3:0]        mod_reg, mod_next;
  logic [pNUM_W-1:0] cnt_reg, cnt_next;
  logic              ovf_reg, ovf_next;
  logic              done;
  logic              accept;

  // One step of the recursive duo-binary trellis.
  function automatic logic [3:0] trellis_step(input logic [3:0] s, input logic [1:0] d);
    logic fb;
    fb = d[1] ^ d[0] ^ s[3] ^ s[2];
    return {s[2], s[1] ^ d[0], s[0] ^ d[0], fb};
  endfunction

  assign accept = iclkena & ival;

  always_comb begin
    fsm_next = fsm_reg;
    s_next   = s_reg;
    mod_next = mod_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    done     = 1'b0;
    if (accept) begin
      if (isop) begin
        // A start always (re)starts from the zero state. In RUN this
        // silently drops the packet that was in progress.
        s_next   = trellis_step(4'd0, idat);
        mod_next = 4'd1;
        cnt_next = {{(pNUM_W-1){1'b0}}, 1'b1};
        ovf_next = 1'b0;
        if (ieop) begin
          done     = 1'b1;
          fsm_next = IDLE;
        end else begin
          fsm_next = RUN;
        end
      end else if (fsm_reg == RUN) begin
        s_next   = trellis_step(s_reg, idat);
        mod_next = (mod_reg == 4'd14) ? 4'd0 : mod_reg + 4'd1;
        // Count saturates; the sticky flag marks the result as unusable
        // while the state and mod15 keep tracking the true length.
        if (cnt_reg == CNT_MAX) begin
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + {{(pNUM_W-1){1'b0}}, 1'b1};
        end
        if (ieop) begin
          done     = 1'b1;
          fsm_next = IDLE;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      fsm_reg <= IDLE;
      s_reg   <= 4'd0;
      mod_reg <= 4'd0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      oval    <= 1'b0;
      ostate  <= 4'd0;
      oNmod15 <= 4'd0;
      onum    <= '0;
      oerr    <= 1'b0;
    end else if (iclkena) begin
      fsm_reg <= fsm_next;
      s_reg   <= s_next;
      mod_reg <= mod_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      oval    <= done;
      // Result registers hold until the next completed packet.
      if (done) begin
        ostate  <= s_next;
        oNmod15 <= mod_next;
        onum    <= cnt_next;
        oerr    <= (mod_next == 4'd0) | ovf_next;
      end
    end
  end

  assign obusy = (fsm_reg == RUN);

endmodule

// File: tb/tb_rsc2_cstate_acc.sv
module tb_rsc2_cstate_acc;

  logic        iclk = 1'b0;
  logic        ireset = 1'b0;
  logic        iclkena = 1'b0;
  logic        ival = 1'b0;
  logic        isop = 1'b0;
  logic        ieop = 1'b0;
  logic [1:0]  idat = 2'b00;

  logic        busy_a, oval_a, err_a;
  logic [3:0]  state_a, mod_a;
  logic [12:0] num_a;
  logic        busy_b, oval_b, err_b;
  logic [3:0]  state_b, mod_b;
  logic [3:0]  num_b;

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;

  logic [1:0] pkt[$];

  always #5 iclk = ~iclk;

  rsc2_cstate_acc #(.pNUM_W(13)) dut_a (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .isop(isop), .ieop(ieop), .idat(idat),
    .obusy(busy_a), .oval(oval_a), .ostate(state_a), .oNmod15(mod_a),
    .onum(num_a), .oerr(err_a)
  );

  rsc2_cstate_acc #(.pNUM_W(4)) dut_b (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .isop(isop), .ieop(ieop), .idat(idat),
    .obusy(busy_b), .oval(oval_b), .ostate(state_b), .oNmod15(mod_b),
    .onum(num_b), .oerr(err_b)
  );

  // Each enabled edge that sees oval high consumes exactly one result pulse.
  always @(posedge iclk) begin
    if (ireset && iclkena && oval_a) pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "timeout");
  end

  // Reference: apply the trellis equations symbol by symbol; length
  // quantities come straight from the packet size.
  task automatic model(output logic [3:0] st, output logic [3:0] m, output int n);
    logic [3:0] s;
    logic       fb;
    s = 4'd0;
    foreach (pkt[i]) begin
      fb = pkt[i][1] ^ pkt[i][0] ^ s[3] ^ s[2];
      s  = {s[2], s[1] ^ pkt[i][0], s[0] ^ pkt[i][0], fb};
    end
    st = s;
    n  = pkt.size();
    m  = 4'(n % 15);
  endtask

  task automatic make_pkt(input int len, input bit rnd);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(rnd ? 2'($urandom) : 2'b00);
  endtask

  task automatic idle_cycle();
    iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    @(posedge iclk); #1;
  endtask

  task automatic send(input bit sop, input bit eop, input logic [1:0] d);
    iclkena = 1'b1; ival = 1'b1; isop = sop; ieop = eop; idat = d;
    @(posedge iclk); #1;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  // Random idle/frozen cycles; junk on the symbol lines is only ever
  // presented while iclkena is low, so it must never be accepted.
  task automatic gap();
    int k;
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      iclkena = 1'($urandom);
      ival    = iclkena ? 1'b0 : 1'($urandom);
      isop    = 1'($urandom);
      ieop    = 1'($urandom);
      idat    = 2'($urandom);
      @(posedge iclk); #1;
    end
  endtask

  task automatic send_pkt(input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) gap();
      send(i == 0, i == pkt.size() - 1, pkt[i]);
    end
  endtask

  task automatic test_reset();
    ireset = 1'b0;
    iclkena = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    n_total++;
    if ({busy_a, oval_a, state_a, mod_a, num_a, err_a} !== 23'd0) $display("FAIL reset_a: got busy/oval/state/mod/num/err=%b/%b/%0d/%0d/%0d/%b, need all 0", busy_a, oval_a, state_a, mod_a, num_a, err_a);
    else n_pass++;
    n_total++;
    if ({busy_b, oval_b, state_b, mod_b, num_b, err_b} !== 14'd0) $display("FAIL reset_b: got busy/oval/state/mod/num/err=%b/%b/%0d/%0d/%0d/%b, need all 0", busy_b, oval_b, state_b, mod_b, num_b, err_b);
    else n_pass++;
    ireset = 1'b1;
    idle_cycle();
    $display("reset: outputs checked");
  endtask

  task automatic test_single();
    send(1'b1, 1'b1, 2'b10);
    n_total++;
    if ({oval_a, state_a, mod_a, err_a, busy_a} !== {1'b1, 4'd1, 4'd1, 1'b0, 1'b0}) $display("FAIL single_result: got oval/state/mod/err/busy=%b/%0d/%0d/%b/%b, need 1/1/1/0/0", oval_a, state_a, mod_a, err_a, busy_a);
    else n_pass++;
    n_total++;
    if (num_a !== 13'd1) $display("FAIL single_num: got %0d, need 1", num_a);
    else n_pass++;
    idle_cycle();
    n_total++;
    if ({oval_a, state_a, mod_a} !== {1'b0, 4'd1, 4'd1}) $display("FAIL single_pulse_end: got oval/state/mod=%b/%0d/%0d, need 0/1/1", oval_a, state_a, mod_a);
    else n_pass++;
    $display("single: state=%0d mod=%0d num=%0d err=%b", state_a, mod_a, num_a, err_a);
  endtask

  task automatic test_zero48();
    make_pkt(48, 1'b0);
    for (int i = 0; i < 48; i++) begin
      send(i == 0, i == 47, pkt[i]);
      if (i == 0) begin
        n_total++;
        if (busy_a !== 1'b1) $display("FAIL zero48_busy: got %b, need 1", busy_a);
        else n_pass++;
      end
    end
    n_total++;
    if ({oval_a, state_a, mod_a, err_a, busy_a} !== {1'b1, 4'd0, 4'd3, 1'b0, 1'b0}) $display("FAIL zero48_result: got oval/state/mod/err/busy=%b/%0d/%0d/%b/%b, need 1/0/3/0/0", oval_a, state_a, mod_a, err_a, busy_a);
    else n_pass++;
    n_total++;
    if (num_a !== 13'd48) $display("FAIL zero48_num: got %0d, need 48", num_a);
    else n_pass++;
    idle_cycle();
    $display("zero48: state=%0d mod=%0d num=%0d", state_a, mod_a, num_a);
  endtask

  task automatic test_wrap();
    int lens[6]  = '{14, 15, 16, 29, 30, 31};
    int mods[6]  = '{14, 0, 1, 14, 0, 1};
    logic [3:0] st, m;
    int n;
    for (int t = 0; t < 6; t++) begin
      make_pkt(lens[t], 1'b1);
      model(st, m, n);
      send_pkt(1'b0);
      n_total++;
      if ({oval_a, state_a, mod_a, err_a} !== {1'b1, st, 4'(mods[t]), (mods[t] == 0)}) $display("FAIL wrap_len%0d: got oval/state/mod/err=%b/%0d/%0d/%b, need 1/%0d/%0d/%0d", lens[t], oval_a, state_a, mod_a, err_a, st, mods[t], mods[t] == 0);
      else n_pass++;
      idle_cycle();
      $display("wrap: len=%0d mod=%0d err=%b", lens[t], mod_a, err_a);
    end
  endtask

  task automatic test_random_long();
    logic [3:0] st, m;
    int n;
    for (int p = 0; p < 2; p++) begin
      make_pkt(1504, 1'b1);
      model(st, m, n);
      send_pkt(1'b0);
      n_total++;
      if ({oval_a, state_a, mod_a, err_a} !== {1'b1, st, 4'd4, 1'b0}) $display("FAIL long%0d: got oval/state/mod/err=%b/%0d/%0d/%b, need 1/%0d/4/0", p, oval_a, state_a, mod_a, err_a, st);
      else n_pass++;
      n_total++;
      if (num_a !== 13'(n)) $display("FAIL long%0d_num: got %0d, need %0d", p, num_a, n);
      else n_pass++;
      idle_cycle();
      $display("long: packet=%0d state=%0d mod=%0d num=%0d", p, state_a, mod_a, num_a);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] st, m;
    int n, p0;
    make_pkt(25, 1'b1);
    model(st, m, n);
    p0 = pulses;
    // Packet that gets aborted by a new isop
    for (int i = 0; i < 7; i++) begin
      gap();
      send(i == 0, 1'b0, 2'($urandom));
    end
    send_pkt(1'b1);
    n_total++;
    if ({oval_a, state_a, mod_a, err_a} !== {1'b1, st, m, (m == 4'd0)}) $display("FAIL gaps_result: got oval/state/mod/err=%b/%0d/%0d/%b, need 1/%0d/%0d/%0d", oval_a, state_a, mod_a, err_a, st, m, m == 4'd0);
    else n_pass++;
    n_total++;
    if (num_a !== 13'(n)) $display("FAIL gaps_num: got %0d, need %0d", num_a, n);
    else n_pass++;
    iclkena = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    n_total++;
    if (oval_a !== 1'b1) $display("FAIL gaps_oval_hold: got %b, need 1", oval_a);
    else n_pass++;
    idle_cycle();
    n_total++;
    if (oval_a !== 1'b0) $display("FAIL gaps_oval_drop: got %b, need 0", oval_a);
    else n_pass++;
    n_total++;
    if (pulses - p0 !== 1) $display("FAIL gaps_pulses: got %0d, need 1", pulses - p0);
    else n_pass++;
    $display("gaps: state=%0d mod=%0d num=%0d pulses=%0d", state_a, mod_a, num_a, pulses - p0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] st1, m1, st2, m2;
    int n1, n2;
    logic [1:0] p2[$];
    make_pkt(9, 1'b1);
    model(st2, m2, n2);
    p2 = pkt;
    make_pkt(17, 1'b1);
    model(st1, m1, n1);
    send_pkt(1'b0);
    n_total++;
    if ({oval_a, state_a, mod_a, num_a} !== {1'b1, st1, m1, 13'(n1)}) $display("FAIL b2b_first: got oval/state/mod/num=%b/%0d/%0d/%0d, need 1/%0d/%0d/%0d", oval_a, state_a, mod_a, num_a, st1, m1, n1);
    else n_pass++;
    for (int i = 0; i < 9; i++) begin
      send(i == 0, i == 8, p2[i]);
      if (i == 4) begin
        n_total++;
        if ({oval_a, state_a, mod_a, num_a, busy_a} !== {1'b0, st1, m1, 13'(n1), 1'b1}) $display("FAIL b2b_hold: got oval/state/mod/num/busy=%b/%0d/%0d/%0d/%b, need 0/%0d/%0d/%0d/1", oval_a, state_a, mod_a, num_a, busy_a, st1, m1, n1);
        else n_pass++;
      end
    end
    n_total++;
    if ({oval_a, state_a, mod_a, num_a} !== {1'b1, st2, m2, 13'(n2)}) $display("FAIL b2b_second: got oval/state/mod/num=%b/%0d/%0d/%0d, need 1/%0d/%0d/%0d", oval_a, state_a, mod_a, num_a, st2, m2, n2);
    else n_pass++;
    idle_cycle();
    $display("b2b: first state=%0d second state=%0d", st1, state_a);
  endtask

  task automatic test_reset_mid();
    logic [3:0] st, m;
    int n, p0;
    make_pkt(20, 1'b1);
    p0 = pulses;
    for (int i = 0; i < 10; i++) send(i == 0, 1'b0, pkt[i]);
    #2 ireset = 1'b0;
    #1;
    n_total++;
    if ({busy_a, oval_a, state_a, mod_a, num_a, err_a} !== 23'd0) $display("FAIL midreset_a: got busy/oval/state/mod/num/err=%b/%b/%0d/%0d/%0d/%b, need all 0", busy_a, oval_a, state_a, mod_a, num_a, err_a);
    else n_pass++;
    n_total++;
    if ({busy_b, oval_b, state_b, mod_b, num_b, err_b} !== 14'd0) $display("FAIL midreset_b: got busy/oval/state/mod/num/err=%b/%b/%0d/%0d/%0d/%b, need all 0", busy_b, oval_b, state_b, mod_b, num_b, err_b);
    else n_pass++;
    @(posedge iclk); #1;
    ireset = 1'b1;
    // Remaining symbols of the killed packet arrive without isop: ignored.
    for (int i = 10; i < 20; i++) send(1'b0, i == 19, pkt[i]);
    idle_cycle();
    n_total++;
    if (pulses - p0 !== 0) $display("FAIL midreset_no_oval: got %0d pulses, need 0", pulses - p0);
    else n_pass++;
    make_pkt(20, 1'b1);
    model(st, m, n);
    send_pkt(1'b0);
    n_total++;
    if ({oval_b, state_b, mod_b, num_b, err_b} !== {1'b1, st, 4'd5, 4'd15, 1'b1}) $display("FAIL sat_b: got oval/state/mod/num/err=%b/%0d/%0d/%0d/%b, need 1/%0d/5/15/1", oval_b, state_b, mod_b, num_b, err_b, st);
    else n_pass++;
    n_total++;
    if ({oval_a, state_a, mod_a, num_a, err_a} !== {1'b1, st, 4'd5, 13'd20, 1'b0}) $display("FAIL nosat_a: got oval/state/mod/num/err=%b/%0d/%0d/%0d/%b, need 1/%0d/5/20/0", oval_a, state_a, mod_a, num_a, err_a, st);
    else n_pass++;
    idle_cycle();
    $display("midreset: narrow num=%0d err=%b mod=%0d", num_b, err_b, mod_b);
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero48();
    test_wrap();
    test_random_long();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rsc2_cstate_acc.md
# rsc2_cstate_acc

Pre-encoding state accumulator for the rsc2 circular (tail-biting) duo-binary encoder. It consumes one duo-binary symbol pair per enabled cycle during the first encoding pass. Starting from the all-zero state, it runs the 16-state recursive trellis and tracks packet length modulo 15. At end of packet it presents the final state S0N and N mod 15 as a registered result, ready to drive the circulation-state correspondence table. That table's output then seeds the second encoding pass.

## Interface
Parameters:
- pNUM_W, 13, width of the packet-length counter in symbols (max N = 2^pNUM_W - 1)

Ports:
- iclk  in  1  clock
- ireset  in  1  reset, asynchronous, active-low
- iclkena  in  1  clock enable; when low all state is frozen
- ival  in  1  symbol valid
- isop  in  1  first symbol of packet, qualified by ival
- ieop  in  1  last symbol of packet, qualified by ival
- idat  in  2  duo-binary symbol, idat[1] = A, idat[0] = B
- obusy  out  1  packet in progress (between accepted isop and accepted ieop)
- oval  out  1  result valid, one enabled-cycle pulse
- ostate  out  4  final trellis state S0N
- oNmod15  out  4  N mod 15, range 0..14
- onum  out  pNUM_W  symbol count N of the finished packet
- oerr  out  1  result unusable: N mod 15 == 0 or length overflow

## Operation
- A symbol is accepted when iclkena & ival. Nothing is accepted when iclkena is low.
- Trellis update per accepted symbol, state s[3:0]:
  - fb = A ^ B ^ s[3] ^ s[2]
  - s_next = {s[2], s[1] ^ B, s[0] ^ B, fb}
- FSM states are IDLE, RUN.
  - IDLE + accepted isop: load s from the update applied to s = 0, load mod15 = 1 and cnt = 1. If ieop is also set, the result is produced and the FSM stays IDLE. Otherwise go to RUN.
  - RUN + accepted symbol (no isop): update s; mod15 = (mod15 == 14) ? 0 : mod15 + 1; cnt = cnt + 1.
  - RUN + accepted ieop: process the symbol, register the result, go to IDLE.
  - RUN + accepted isop: abort the current packet silently (no oval) and restart as from IDLE with this symbol.
  - IDLE + accepted symbol without isop: ignored, no state change.
- Length overflow: if cnt would exceed 2^pNUM_W - 1, set a sticky overflow flag and saturate cnt. mod15 and s continue to update.
- Result registers: ostate = final s, oNmod15 = final mod15, onum = final cnt.
  - oerr = (final mod15 == 0) | overflow.
  - Results hold until the next result. The row-0 LUT entry is meaningless, so downstream must discard ostate/oNmod15 when oerr = 1.
- obusy = (FSM == RUN).

## Timing
- Reset values: obusy = 0, oval = 0, ostate = 0, oNmod15 = 0, onum = 0, oerr = 0. FSM enters IDLE; internal s, mod15, cnt and overflow are cleared.
- Latency: the result registers and oval update on the first clock edge where iclkena = 1 and ieop is accepted. oval is visible the following cycle. oval deasserts at the next enabled edge. While iclkena is low, oval holds its value.
- Back-to-back packets: isop may be accepted on the enabled cycle right after ieop. The result of packet k stays stable while packet k+1 accumulates.
- Reset asserted mid-packet: everything clears immediately and no oval is produced.
- No backpressure. The consumer must sample the result within the oval cycle or before the next ieop.

## Test plan
- Single-symbol packet: isop & ieop with idat = 2'b10 (A = 1, B = 0) -> oval next cycle; ostate = 1, oNmod15 = 1, onum = 1, oerr = 0.
- All-zero 48-symbol packet -> ostate = 0, oNmod15 = 3, onum = 48, oerr = 0.
- 30-symbol packet -> oNmod15 = 0, oerr = 1. Also check the mod15 wrap 14 -> 0 at symbols 15 and 30.
- Random 1504-symbol packets checked against a reference model of the update equations -> ostate and oNmod15 match; oNmod15 = 4.
- iclkena toggled randomly with ival gaps, plus an isop mid-packet -> results identical to a gap-free run; the aborted packet produces no oval.
- Async reset mid-packet, with pNUM_W = 4 and a 20-symbol packet -> outputs are 0 immediately after reset. The next 20-symbol packet gives onum = 15 (saturated), oerr = 1, oNmod15 = 5.
